// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: packs decoded fields into instruction words with a running write address.
// Optional immediate range/alignment checks (error codes 4/5) are enabled by defining ENC_IMM_CHECK_EN.
module instr_encoder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned BASE_ADDR   = 0,
  parameter bit          STOP_ON_ERR = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [2:0]        err_code
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, HOLD, HALT} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [31:0]       out_instr_q;
  logic              out_valid_q;
  logic              err_q;
  logic [2:0]        err_code_q;

  logic [31:0] enc_word;
  logic [2:0]  chk_code;
  logic        known, f3_bad, f7_bad, is_shift, accept;

  assign is_shift = (in_opcode == OP_OPIMM) && (in_funct3 == 3'b001 || in_funct3 == 3'b101);
  assign in_ready = !clr && ((state_q == IDLE) || (state_q == HOLD && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    enc_word = 32'h0000_0013;
    case (in_opcode)
      OP_OPIMM, OP_JALR, OP_LOAD:
        enc_word = is_shift ? {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode}
                            : {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      OP_LUI, OP_AUIPC:
        enc_word = {in_imm[31:12], in_rd, in_opcode};
      OP_JAL:
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      OP_STORE:
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      OP_BRANCH:
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], in_opcode};
      OP_OP:
        enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      default: enc_word = 32'h0000_0013;
    endcase
  end

  always_comb begin
    known  = 1'b1;
    f3_bad = 1'b0;
    f7_bad = 1'b0;
    case (in_opcode)
      OP_LOAD:   f3_bad = (in_funct3 == 3'b011) || (in_funct3 == 3'b110) || (in_funct3 == 3'b111);
      OP_STORE:  f3_bad = (in_funct3 >= 3'b011);
      OP_BRANCH: f3_bad = (in_funct3 == 3'b010) || (in_funct3 == 3'b011);
      OP_JALR:   f3_bad = (in_funct3 != 3'b000);
      OP_OPIMM: begin
        if (in_funct3 == 3'b001)
          f7_bad = (in_funct7 != 7'b0000000);
        else if (in_funct3 == 3'b101)
          f7_bad = !(in_funct7 == 7'b0000000 || in_funct7 == 7'b0100000);
      end
      OP_OP: f7_bad = !(in_funct7 == 7'b0000000 ||
                        (in_funct7 == 7'b0100000 && (in_funct3 == 3'b000 || in_funct3 == 3'b101)));
      OP_LUI, OP_AUIPC, OP_JAL: known = 1'b1;
      default: known = 1'b0;
    endcase
  end

`ifdef ENC_IMM_CHECK_EN
  logic imm_bad, misal;
  always_comb begin
    imm_bad = 1'b0;
    misal   = 1'b0;
    case (in_opcode)
      OP_OPIMM, OP_JALR, OP_LOAD, OP_STORE:
        imm_bad = is_shift ? (|in_imm[31:5]) : !((&in_imm[31:11]) || !(|in_imm[31:11]));
      OP_BRANCH: begin
        imm_bad = !((&in_imm[31:12]) || !(|in_imm[31:12]));
        misal   = in_imm[0];
      end
      OP_JAL: begin
        imm_bad = !((&in_imm[31:20]) || !(|in_imm[31:20]));
        misal   = in_imm[0];
      end
      OP_LUI, OP_AUIPC: imm_bad = |in_imm[11:0];
      default: imm_bad = 1'b0;
    endcase
  end
`endif

  // Lowest-numbered applicable error wins.
  always_comb begin
    chk_code = 3'd0;
    if (!known)      chk_code = 3'd1;
    else if (f3_bad) chk_code = 3'd2;
    else if (f7_bad) chk_code = 3'd3;
`ifdef ENC_IMM_CHECK_EN
    else if (imm_bad) chk_code = 3'd4;
    else if (misal)   chk_code = 3'd5;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= BASE;
      out_addr_q  <= BASE;
      out_instr_q <= 32'h0000_0013;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 3'd0;
    end else begin
      if (clr) begin
        cnt_q      <= BASE;
        err_q      <= 1'b0;
        err_code_q <= 3'd0;
        if (state_q == HALT) state_q <= IDLE;
      end
      // accept never coincides with clr, so the two branches do not compete.
      if (accept) begin
        if (chk_code == 3'd0) begin
          out_instr_q <= enc_word;
          out_addr_q  <= cnt_q;
          cnt_q       <= cnt_q + ADDR_W'(1);
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
        end else begin
          err_q <= 1'b1;
          if (!err_q) err_code_q <= chk_code;
          out_valid_q <= 1'b0;
          state_q     <= STOP_ON_ERR ? HALT : IDLE;
        end
      end else if (state_q == HOLD && out_ready) begin
        out_valid_q <= 1'b0;
        state_q     <= IDLE;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: vector table for encodings/errors plus handshake, clr, wrap and reset sequences.
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid, out_ready;
  logic [6:0]  in_opcode, in_funct7;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        in_ready, out_valid, err;
  logic [31:0] out_instr;
  logic [7:0]  out_addr;
  logic [2:0]  err_code;
  logic        w_in_ready, w_out_valid, w_err;
  logic [31:0] w_out_instr;
  logic [1:0]  w_out_addr;
  logic [2:0]  w_err_code;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(0), .STOP_ON_ERR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err(err), .err_code(err_code));

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0), .STOP_ON_ERR(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_instr(w_out_instr),
    .out_addr(w_out_addr), .err(w_err), .err_code(w_err_code));

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];
  vec_t errs[8];

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm, input logic [31:0] exp);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else
      $display("ok   %s: 0x%08h", name, act);
  endtask

  task automatic drive(input vec_t v);
    in_opcode = v.op; in_funct3 = v.f3; in_funct7 = v.f7;
    in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_clr();
    in_valid = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk(7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5,         32'h0050_0093); // ADDI x1,x0,5
    vecs[1]  = mk(7'b1100011, 3'b000, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 32'hFE20_8CE3); // BEQ x1,x2,-8
    vecs[2]  = mk(7'b0100011, 3'b010, 7'h00, 5'd0, 5'd2, 5'd5, 32'd12,        32'h0051_2623); // SW x5,12(x2)
    vecs[3]  = mk(7'b0110111, 3'b000, 7'h00, 5'd3, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_51B7); // LUI
    vecs[4]  = mk(7'b1101111, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h0010_00EF); // JAL x1,2048
    vecs[5]  = mk(7'b0010011, 3'b101, 7'h20, 5'd4, 5'd5, 5'd0, 32'd3,         32'h4032_D213); // SRAI
    vecs[6]  = mk(7'b0110011, 3'b000, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0,         32'h4020_81B3); // SUB
    vecs[7]  = mk(7'b0000011, 3'b010, 7'h00, 5'd6, 5'd7, 5'd0, 32'hFFFF_FFFC, 32'hFFC3_A303); // LW
    vecs[8]  = mk(7'b1100111, 3'b000, 7'h00, 5'd0, 5'd1, 5'd0, 32'd0,         32'h0000_8067); // JALR
    vecs[9]  = mk(7'b0010111, 3'b000, 7'h00, 5'd5, 5'd0, 5'd0, 32'hFFFF_F000, 32'hFFFF_F297); // AUIPC
    vecs[10] = mk(7'b1100011, 3'b001, 7'h00, 5'd0, 5'd3, 5'd4, 32'd16,        32'h0041_9863); // BNE +16
    vecs[11] = mk(7'b0010011, 3'b001, 7'h00, 5'd1, 5'd1, 5'd0, 32'd31,        32'h01F0_9093); // SLLI 31

    errs[0] = mk(7'b0000011, 3'b011, 7'h00, 5'd1, 5'd1, 5'd0, 32'd0, 32'd2); // LOAD f3 011
    errs[1] = mk(7'b0100011, 3'b011, 7'h00, 5'd0, 5'd1, 5'd2, 32'd0, 32'd2); // STORE f3 011
    errs[2] = mk(7'b1100011, 3'b010, 7'h00, 5'd0, 5'd1, 5'd2, 32'd0, 32'd2); // BRANCH f3 010
    errs[3] = mk(7'b1100111, 3'b001, 7'h00, 5'd0, 5'd1, 5'd0, 32'd0, 32'd2); // JALR f3 001
    errs[4] = mk(7'b0110011, 3'b001, 7'h20, 5'd1, 5'd1, 5'd2, 32'd0, 32'd3); // SLL with 0100000
    errs[5] = mk(7'b0110011, 3'b000, 7'h01, 5'd1, 5'd1, 5'd2, 32'd0, 32'd3); // funct7 0000001
    errs[6] = mk(7'b0010011, 3'b001, 7'h20, 5'd1, 5'd1, 5'd0, 32'd1, 32'd3); // SLLI funct7 != 0
    errs[7] = mk(7'b1111111, 3'b011, 7'h7F, 5'd1, 5'd1, 5'd0, 32'd0, 32'd1); // bad opcode wins

    in_opcode = '0; in_funct3 = '0; in_funct7 = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    do_reset();

    // Reset state
    #1;
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst out_instr", out_instr, 32'h0000_0013);
    check("rst out_addr", {24'd0, out_addr}, 32'd0);
    check("rst err", {31'd0, err}, 32'd0);
    check("rst err_code", {29'd0, err_code}, 32'd0);
    check("rst in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back stream of legal encodings
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i]); in_valid = 1'b1;
      #1 check($sformatf("vec%0d in_ready", i), {31'd0, in_ready}, 32'd1);
      tick();
      check($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("vec%0d instr", i), out_instr, vecs[i].exp);
      check($sformatf("vec%0d addr", i), {24'd0, out_addr}, i);
    end
    in_valid = 1'b0;
    tick();
    check("drain out_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: word A held for 3 cycles while B waits
    do_reset();
    drive(vecs[0]); in_valid = 1'b1; out_ready = 1'b0;
    tick();
    drive(vecs[1]);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp%0d in_ready", c), {31'd0, in_ready}, 32'd0);
      check($sformatf("bp%0d instr", c), out_instr, vecs[0].exp);
      check($sformatf("bp%0d addr", c), {24'd0, out_addr}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1 check("bp release in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("bp B instr", out_instr, vecs[1].exp);
    check("bp B addr", {24'd0, out_addr}, 32'd1);
    drive(vecs[2]);
    tick();
    check("bp C instr", out_instr, vecs[2].exp);
    check("bp C addr", {24'd0, out_addr}, 32'd2);
    in_valid = 1'b0;
    tick();
    check("bp drained", {31'd0, out_valid}, 32'd0);

    // Error codes table, clr before each
    for (int i = 0; i < 8; i++) begin
      pulse_clr();
      drive(errs[i]); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      #1;
      check($sformatf("err%0d err", i), {31'd0, err}, 32'd1);
      check($sformatf("err%0d code", i), {29'd0, err_code}, errs[i].exp);
      check($sformatf("err%0d out_valid", i), {31'd0, out_valid}, 32'd0);
      check($sformatf("err%0d halted in_ready", i), {31'd0, in_ready}, 32'd0);
    end

    // Sticky first code; STOP_ON_ERR=0 instance keeps accepting
    pulse_clr();
    drive(errs[6]); in_valid = 1'b1;
    tick();
    drive(errs[0]);
    tick();
    in_valid = 1'b0;
    #1;
    check("sticky w_err_code", {29'd0, w_err_code}, 32'd3);
    check("sticky w_err", {31'd0, w_err}, 32'd1);
    check("sticky w_in_ready", {31'd0, w_in_ready}, 32'd1);
    check("sticky err_code", {29'd0, err_code}, 32'd3);

    // Bad opcode halts until clr; next legal word restarts at address 0
    do_reset();
    drive(vecs[0]); in_valid = 1'b1;
    tick();
    check("halt pre addr", {24'd0, out_addr}, 32'd0);
    drive(errs[7]);
    tick();
    drive(vecs[3]);
    #1;
    check("halt err_code", {29'd0, err_code}, 32'd1);
    check("halt out_valid", {31'd0, out_valid}, 32'd0);
    check("halt in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("halt still no output", {31'd0, out_valid}, 32'd0);
    pulse_clr();
    #1;
    check("clr err", {31'd0, err}, 32'd0);
    check("clr err_code", {29'd0, err_code}, 32'd0);
    check("clr in_ready", {31'd0, in_ready}, 32'd1);
    drive(vecs[3]); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post clr instr", out_instr, vecs[3].exp);
    check("post clr addr", {24'd0, out_addr}, 32'd0);

    // ADDI imm 4096: range error or silent truncation depending on build
    do_reset();
    drive(mk(7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd4096, 32'd0)); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
`ifdef ENC_IMM_CHECK_EN
    check("imm4096 err_code", {29'd0, err_code}, 32'd4);
    check("imm4096 out_valid", {31'd0, out_valid}, 32'd0);
`else
    check("imm4096 instr", out_instr, 32'h0000_0093);
    check("imm4096 err", {31'd0, err}, 32'd0);
`endif

    // ADDR_W=2 wrap, then async reset while holding a word
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(vecs[k]); in_valid = 1'b1;
      tick();
      check($sformatf("wrap%0d addr", k), {30'd0, w_out_addr}, k % 4);
      check($sformatf("wrap%0d instr", k), w_out_instr, vecs[k].exp);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    check("hold before rst", {31'd0, w_out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async rst w_out_valid", {31'd0, w_out_valid}, 32'd0);
    check("async rst out_valid", {31'd0, out_valid}, 32'd0);
    check("async rst out_instr", out_instr, 32'h0000_0013);
    tick();
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
